// File: rtl/grant_write_queue_if.sv
// Client write channel and shared-RAM write port of one grant_write_queue instance.
// The slave modport is the queue; the master modport is the client/RAM side.
interface grant_write_queue_if #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 8,
   parameter int CNT_W  = 4
);
   logic              wr_valid;
   logic              wr_ready;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              ram_we;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_wdata;
   logic [CNT_W-1:0]  count;
   logic              empty;
   logic              full;
   logic [15:0]       stall_cnt;

   modport slave (
      input  wr_valid, wr_addr, wr_data,
      output wr_ready, ram_we, ram_addr, ram_wdata, count, empty, full, stall_cnt
   );

   modport master (
      output wr_valid, wr_addr, wr_data,
      input  wr_ready, ram_we, ram_addr, ram_wdata, count, empty, full, stall_cnt
   );
endinterface

// File: rtl/grant_write_queue.sv
// Buffers client RAM writes and drains them only while this client's CE grant is held.
// Optional back-pressure counter on stall_cnt is enabled by defining GRANT_QUEUE_STATS_EN.
//
// state | meaning
// IDLE  | no grant; writes accumulate in the queue
// GUARD | grant seen for one cycle; hold off RAM access
// DRAIN | grant held; issue one queued write per cycle while ce stays high
module grant_write_queue #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 8,
   parameter int DEPTH  = 8,
   parameter int CNT_W  = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                ce,
   grant_write_queue_if.slave  bus
);

   localparam int PTR_W = $clog2(DEPTH);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GUARD = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t                   state, state_nxt;
   logic [PTR_W-1:0]         head, tail;
   logic [CNT_W-1:0]         count_q;
   logic [ADDR_W+DATA_W-1:0] mem [DEPTH];
   logic                     push, issue;

   assign bus.full     = (count_q == CNT_W'(DEPTH));
   assign bus.empty    = (count_q == '0);
   assign bus.count    = count_q;
   assign bus.wr_ready = !bus.full;

   assign push  = bus.wr_valid && bus.wr_ready;
   // Reset is gated in so a write cannot escape during the reset cycle itself.
   assign issue = (state == DRAIN) && ce && !bus.empty && !reset;

   assign bus.ram_we                      = issue;
   assign {bus.ram_addr, bus.ram_wdata}   = mem[head];

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (ce) state_nxt = GUARD;
         GUARD:   state_nxt = ce ? DRAIN : IDLE;
         DRAIN:   if (!ce) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (push) mem[tail] <= {bus.wr_addr, bus.wr_data};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         head    <= '0;
         tail    <= '0;
         count_q <= '0;
      end else begin
         if (push)  tail <= tail + PTR_W'(1);
         if (issue) head <= head + PTR_W'(1);
         case ({push, issue})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
      end
   end

`ifdef GRANT_QUEUE_STATS_EN
   logic [15:0] stall_q;

   always_ff @(posedge clk) begin
      if (reset)                                              stall_q <= '0;
      else if (bus.wr_valid && !bus.wr_ready && stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
   end

   assign bus.stall_cnt = stall_q;
`else
   assign bus.stall_cnt = '0;
`endif

endmodule

// File: tb/tb_grant_write_queue.sv
// Directed bench for grant_write_queue: fill/drain, guard latency, wrap, ce drop and reset mid-drain.
module tb_grant_write_queue;

   localparam int ADDR_W = 12;
   localparam int DATA_W = 8;
   localparam int DEPTH  = 8;
   localparam int CNT_W  = 4;
`ifdef GRANT_QUEUE_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset;
   logic ce;
   int   checks = 0;
   int   errors = 0;

   grant_write_queue_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

   grant_write_queue #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk   (clk),
      .reset (reset),
      .ce    (ce),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   function automatic logic [ADDR_W-1:0] a_of(input int i);
      return ADDR_W'(12'h100 + i);
   endfunction

   function automatic logic [DATA_W-1:0] d_of(input int i);
      return DATA_W'(8'h5A ^ i);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; inputs for the next cycle are driven 1ns after the edge.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input int i);
      bus.wr_valid = v;
      bus.wr_addr  = a_of(i);
      bus.wr_data  = d_of(i);
   endtask

   task automatic chk_issue(input string tag, input int i);
      chk({tag, "_we"},   32'(bus.ram_we),    32'd1);
      chk({tag, "_addr"}, 32'(bus.ram_addr),  32'(a_of(i)));
      chk({tag, "_data"}, 32'(bus.ram_wdata), 32'(d_of(i)));
   endtask

   initial begin
      reset = 1'b1;
      ce    = 1'b0;
      drive(1'b0, 0);
      #1;
      cyc();
      cyc();
      reset = 1'b0;
      #1;
      chk("rst_count",    32'(bus.count),     32'd0);
      chk("rst_empty",    32'(bus.empty),     32'd1);
      chk("rst_full",     32'(bus.full),      32'd0);
      chk("rst_wr_ready", 32'(bus.wr_ready),  32'd1);
      chk("rst_ram_we",   32'(bus.ram_we),    32'd0);
      chk("rst_stall",    32'(bus.stall_cnt), 32'd0);

      // Three pushes with no grant.
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, i);
         #1;
         chk("fill3_ready", 32'(bus.wr_ready), 32'd1);
         chk("fill3_we",    32'(bus.ram_we),   32'd0);
         cyc();
      end
      drive(1'b0, 0);
      #1;
      chk("fill3_count", 32'(bus.count),  32'd3);
      chk("fill3_we2",   32'(bus.ram_we), 32'd0);

      // Grant rises at T: two silent cycles, then A0..A2.
      ce = 1'b1;
      #1;
      chk("guard_T",  32'(bus.ram_we), 32'd0);
      cyc();
      chk("guard_T1", 32'(bus.ram_we), 32'd0);
      cyc();
      for (int i = 0; i < 3; i++) begin
         chk_issue("drain3", i);
         cyc();
      end
      chk("drain3_empty", 32'(bus.empty),  32'd1);
      chk("drain3_we",    32'(bus.ram_we), 32'd0);
      cyc();
      chk("drain_wait_we", 32'(bus.ram_we), 32'd0);

      // Nine back-to-back pushes without grant; the ninth is held for three cycles.
      ce = 1'b0;
      cyc();
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, 16 + i);
         #1;
         chk("fill8_ready", 32'(bus.wr_ready), 32'd1);
         chk("fill8_count", 32'(bus.count),    32'(i));
         cyc();
      end
      drive(1'b1, 24);
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("hold9_ready", 32'(bus.wr_ready), 32'd0);
         chk("hold9_full",  32'(bus.full),     32'd1);
         chk("hold9_we",    32'(bus.ram_we),   32'd0);
         cyc();
      end
      drive(1'b0, 0);
      #1;
      chk("hold9_count", 32'(bus.count),     32'd8);
      chk("hold9_stall", 32'(bus.stall_cnt), STATS ? 32'd3 : 32'd0);

      // Grant, drain four, then push+pop every cycle for 20 cycles across wraps.
      ce = 1'b1;
      cyc();
      chk("g2_T1", 32'(bus.ram_we), 32'd0);
      cyc();
      for (int j = 0; j < 4; j++) begin
         chk_issue("drain4", 16 + j);
         cyc();
      end
      chk("steady_count0", 32'(bus.count), 32'd4);
      for (int j = 0; j < 20; j++) begin
         drive(1'b1, 32 + j);
         #1;
         chk("steady_count", 32'(bus.count),    32'd4);
         chk("steady_ready", 32'(bus.wr_ready), 32'd1);
         chk_issue("steady", (j < 4) ? (20 + j) : (32 + j - 4));
         cyc();
      end
      drive(1'b0, 0);
      ce = 1'b0;
      #1;
      chk("steady_end_count", 32'(bus.count),  32'd4);
      chk("ce_low_we",        32'(bus.ram_we), 32'd0);
      cyc();

      // Five queued (48..52); drop ce after two issues, then re-grant.
      drive(1'b1, 52);
      cyc();
      drive(1'b0, 0);
      ce = 1'b1;
      #1;
      chk("five_count", 32'(bus.count),  32'd5);
      chk("g3_T",       32'(bus.ram_we), 32'd0);
      cyc();
      chk("g3_T1",      32'(bus.ram_we), 32'd0);
      cyc();
      chk_issue("pre_drop", 48);
      cyc();
      chk_issue("pre_drop", 49);
      cyc();
      ce = 1'b0;
      #1;
      chk("drop_we", 32'(bus.ram_we), 32'd0);
      cyc();
      chk("drop_count", 32'(bus.count), 32'd3);
      ce = 1'b1;
      #1;
      chk("regrant_T", 32'(bus.ram_we), 32'd0);
      cyc();
      chk("regrant_T1", 32'(bus.ram_we), 32'd0);
      cyc();
      for (int i = 50; i < 53; i++) begin
         chk_issue("regrant", i);
         cyc();
      end
      chk("regrant_empty", 32'(bus.empty), 32'd1);

      // Reset while draining with five entries queued.
      ce = 1'b0;
      cyc();
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 64 + i);
         cyc();
      end
      drive(1'b0, 0);
      ce = 1'b1;
      cyc();
      cyc();
      chk("prerst_count", 32'(bus.count), 32'd5);
      reset = 1'b1;
      #1;
      chk("rstcyc_we", 32'(bus.ram_we), 32'd0);
      cyc();
      reset = 1'b0;
      drive(1'b1, 70);
      #1;
      chk("postrst_count", 32'(bus.count),     32'd0);
      chk("postrst_empty", 32'(bus.empty),     32'd1);
      chk("postrst_we",    32'(bus.ram_we),    32'd0);
      chk("postrst_stall", 32'(bus.stall_cnt), 32'd0);
      cyc();
      drive(1'b0, 0);
      #1;
      chk("postrst_guard_we", 32'(bus.ram_we), 32'd0);
      chk("postrst_count1",   32'(bus.count),  32'd1);
      cyc();
      chk_issue("postrst", 70);
      cyc();
      chk("final_empty", 32'(bus.empty), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
